// File: rtl/booth_mult_arbiter_pkg.sv
// booth_mult_pkg: shared operand/product widths and arbiter state encoding
//   MUL_W  : operand width used by the arbiter and the booth_multiplier
//   PROD_W : product width (2*MUL_W)
//   state_t: arbiter FSM states, 3-bit encoding
package booth_mult_pkg;
   localparam int MUL_W  = 8;
   localparam int PROD_W = 2 * MUL_W;
   typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DONE, ABORT, RECOVER} state_t;
endpackage

// File: rtl/booth_mult_arbiter_if.sv
// booth_mult_arbiter_if: requester-side and multiplier-side signals of the arbiter
//   req/a_in/b_in       : per-requester request and packed operands
//   grant/done/err      : per-requester one-hot grant, done and timeout pulses
//   result/busy         : latched product and activity flag
//   mul_en/mul_a/mul_b  : drive the shared booth_multiplier
//   mul_out/mul_ready   : returned by the booth_multiplier
//   slave = arbiter side, master = clients plus multiplier side
interface booth_mult_arbiter_if
   import booth_mult_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int W     = MUL_W
);
   logic [N_REQ-1:0]   req, grant, done, err;
   logic [N_REQ*W-1:0] a_in, b_in;
   logic [2*W-1:0]     result, mul_out;
   logic [W-1:0]       mul_a, mul_b;
   logic               busy, mul_en, mul_ready;
   modport slave (
      input  req, a_in, b_in, mul_out, mul_ready,
      output grant, done, err, result, busy, mul_en, mul_a, mul_b
   );
   modport master (
      output req, a_in, b_in, mul_out, mul_ready,
      input  grant, done, err, result, busy, mul_en, mul_a, mul_b
   );
endinterface

// File: rtl/booth_mult_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker
//   i_req   : request vector
//   i_ptr   : highest-priority index
//   o_grant : one-hot of the first set request at or after i_ptr (wrapping), 0 if none
//   o_idx   : index of that request
module rr_pick #(
   parameter int N_REQ = 4
) (
   input  logic [N_REQ-1:0]         i_req,
   input  logic [$clog2(N_REQ)-1:0] i_ptr,
   output logic [N_REQ-1:0]         o_grant,
   output logic [$clog2(N_REQ)-1:0] o_idx
);
   localparam int IW = $clog2(N_REQ);
   // scan from farthest to nearest so the requester closest to i_ptr is written last
   always_comb begin
      o_grant = '0;
      o_idx   = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         if (i_req[(int'(i_ptr) + k) % N_REQ]) begin
            o_grant = N_REQ'(1) << ((int'(i_ptr) + k) % N_REQ);
            o_idx   = IW'((int'(i_ptr) + k) % N_REQ);
         end
      end
   end
endmodule

// File: rtl/booth_mult_arbiter.sv
// booth_mult_arbiter: shares one booth_multiplier between N_REQ requesters, round-robin
//   clk, reset : system clock, synchronous active-high reset
//   bus        : booth_mult_arbiter_if.slave (requester and multiplier signals)
module booth_mult_arbiter
   import booth_mult_pkg::*;
#(
   parameter int N_REQ   = 4,
   parameter int W       = MUL_W,
   parameter int TIMEOUT = 32
) (
   input logic                 clk,
   input logic                 reset,
   booth_mult_arbiter_if.slave bus
);
   localparam int IW = $clog2(N_REQ);
   localparam int CW = $clog2(TIMEOUT + 1);
   state_t           r_state, w_next;
   logic [IW-1:0]    r_ptr, r_idx, w_idx;
   logic [N_REQ-1:0] w_pick, r_grant, r_done, r_err;
   logic [CW-1:0]    r_cnt;
   logic [W-1:0]     r_a, r_b;
   logic [2*W-1:0]   r_result;
   logic             r_en, w_timeout;
   rr_pick #(.N_REQ(N_REQ)) u_pick (
      .i_req  (bus.req),
      .i_ptr  (r_ptr),
      .o_grant(w_pick),
      .o_idx  (w_idx)
   );
   assign w_timeout  = r_cnt == CW'(TIMEOUT - 1);
   assign bus.grant  = r_grant;
   assign bus.done   = r_done;
   assign bus.err    = r_err;
   assign bus.result = r_result;
   assign bus.busy   = r_state != IDLE;
   assign bus.mul_en = r_en;
   assign bus.mul_a  = r_a;
   assign bus.mul_b  = r_b;
   always_ff @(posedge clk) r_state <= reset ? IDLE : w_next;
   // ready is only looked at in WAIT and beats a coinciding timeout
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:        w_next = |bus.req ? ISSUE : IDLE;
         ISSUE:       w_next = WAIT;
         WAIT:        w_next = bus.mul_ready ? DONE : w_timeout ? ABORT : WAIT;
         DONE, ABORT: w_next = RECOVER;
         default:     w_next = IDLE;
      endcase
   end
   // outputs are registered from the current state, so en is low in RECOVER
   // and done/err pulse in the cycle after DONE/ABORT
   always_ff @(posedge clk) begin
      if (reset) begin
         r_ptr    <= '0;
         r_idx    <= '0;
         r_grant  <= '0;
         r_done   <= '0;
         r_err    <= '0;
         r_cnt    <= '0;
         r_a      <= '0;
         r_b      <= '0;
         r_result <= '0;
         r_en     <= 1'b0;
      end else begin
         r_en   <= r_state == ISSUE || r_state == WAIT;
         r_done <= (r_state == DONE && bus.req[r_idx]) ? r_grant : '0;
         r_err  <= (r_state == ABORT && bus.req[r_idx]) ? r_grant : '0;
         if (r_state == IDLE && |bus.req) begin
            r_idx   <= w_idx;
            r_grant <= w_pick;
            r_a     <= bus.a_in[int'(w_idx)*W +: W];
            r_b     <= bus.b_in[int'(w_idx)*W +: W];
            r_cnt   <= '0;
         end
         if (r_state == WAIT) r_cnt <= r_cnt + CW'(1);
         if (r_state == WAIT && bus.mul_ready) r_result <= bus.mul_out;
         if (r_state == DONE || r_state == ABORT) r_grant <= '0;
         if (r_state == RECOVER) r_ptr <= r_idx == IW'(N_REQ - 1) ? '0 : r_idx + IW'(1);
      end
   end
endmodule

// File: tb/tb_booth_mult_arbiter.sv
// tb_booth_mult_arbiter: directed stimulus against a transaction-timeline model of the arbiter
module tb_booth_mult_arbiter;
   import booth_mult_pkg::*;
   localparam int N = 4;
   localparam int T = 32;
   logic clk = 1'b0, reset = 1'b1;
   int   n_tests = 0, n_fail = 0;
   int   lat = 3;
   int   mcnt = 0;
   bit   started = 1'b0;
   logic [15:0] t2p [4] = '{16'h000C, 16'hFFF2, 16'h3F01, 16'h4000};
   always #5 clk = ~clk;
   booth_mult_arbiter_if #(.N_REQ(N), .W(8)) bus ();
   booth_mult_arbiter #(.N_REQ(N), .W(8), .TIMEOUT(T)) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );
   // stand-in multiplier: ready after en has been high for lat cycles, garbage output otherwise
   always @(posedge clk) mcnt <= bus.mul_en ? mcnt + 1 : 0;
   assign bus.mul_ready = bus.mul_en && mcnt >= lat;
   assign bus.mul_out   = bus.mul_ready ? 16'($signed(bus.mul_a)) * 16'($signed(bus.mul_b)) : 16'h5A5A;
   function automatic int pick(input logic [N-1:0] r, input int p);
      for (int k = 0; k < N; k++) if (r[(p + k) % N]) return (p + k) % N;
      return 0;
   endfunction
   function automatic logic [15:0] prod(input logic signed [7:0] a, input logic signed [7:0] b);
      int p;
      p = a * b;
      return p[15:0];
   endfunction
   // model: an operation is a timeline k=0.. from the grant cycle; it ends (DONE/ABORT)
   // at k=e, pulses at e+1 and frees the arbiter at e+2
   bit          m_act = 0, m_to = 0, m_ok = 0;
   int          m_k = 0, m_e = 0, m_w = 0, m_ptr = 0;
   logic [15:0] m_res = 0, m_prod = 0;
   logic [7:0]  m_a = 0, m_b = 0;
   always @(posedge clk) begin
      started <= 1'b1;
      if (reset) begin
         m_act <= 0; m_k <= 0; m_ptr <= 0; m_res <= 0; m_a <= 0; m_b <= 0; m_ok <= 0;
      end else if (!m_act) begin
         if (|bus.req) begin
            m_w    <= pick(bus.req, m_ptr);
            m_a    <= bus.a_in[pick(bus.req, m_ptr)*8 +: 8];
            m_b    <= bus.b_in[pick(bus.req, m_ptr)*8 +: 8];
            m_prod <= prod(bus.a_in[pick(bus.req, m_ptr)*8 +: 8], bus.b_in[pick(bus.req, m_ptr)*8 +: 8]);
            m_to   <= lat >= T;
            m_e    <= lat >= T ? T + 1 : lat + 2;
            m_act  <= 1; m_k <= 0; m_ok <= 0;
         end
      end else begin
         m_k <= m_k + 1;
         if (m_k == m_e) m_ok <= bus.req[m_w];
         if (m_k + 1 == m_e && !m_to) m_res <= m_prod;
         if (m_k + 1 == m_e + 2) begin
            m_act <= 0;
            m_ptr <= (m_w + 1) % N;
         end
      end
   end
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask
   always @(negedge clk) if (started) begin
      chk("grant", 32'(bus.grant), (m_act && m_k <= m_e) ? 32'(1) << m_w : 32'(0));
      chk("done", 32'(bus.done), (m_act && m_k == m_e + 1 && !m_to && m_ok) ? 32'(1) << m_w : 32'(0));
      chk("err", 32'(bus.err), (m_act && m_k == m_e + 1 && m_to && m_ok) ? 32'(1) << m_w : 32'(0));
      chk("mul_en", 32'(bus.mul_en), 32'(m_act && m_k >= 1 && m_k <= m_e));
      chk("busy", 32'(bus.busy), 32'(m_act));
      chk("result", 32'(bus.result), 32'(m_res));
      chk("mul_a", 32'(bus.mul_a), 32'(m_a));
      chk("mul_b", 32'(bus.mul_b), 32'(m_b));
      chk("grant_onehot", 32'($onehot0(bus.grant)), 32'(1));
   end
   task automatic set_op(input int i, input logic [7:0] a, input logic [7:0] b);
      bus.a_in[i*8 +: 8] = a;
      bus.b_in[i*8 +: 8] = b;
   endtask
   task automatic wait_grant(output int idx);
      idx = -1;
      for (int c = 0; c < 100 && idx < 0; c++) begin
         @(negedge clk);
         for (int i = 0; i < N; i++) if (bus.grant[i]) idx = i;
      end
      if (idx < 0) begin
         n_tests++; n_fail++;
         $display("FAIL wait_grant: got no grant, required one within 100 cycles");
      end
   endtask
   task automatic wait_pulse(output int idx, output bit is_err, output int cyc);
      idx = -1; is_err = 0; cyc = 0;
      while (idx < 0 && cyc < 200) begin
         @(negedge clk);
         cyc++;
         for (int i = 0; i < N; i++) if (bus.done[i] || bus.err[i]) begin idx = i; is_err = bus.err[i]; end
      end
      if (idx < 0) begin
         n_tests++; n_fail++;
         $display("FAIL wait_pulse: got no done/err, required one within 200 cycles");
      end
   endtask
   initial begin
      int g, p, c, n;
      bit e;
      bus.req = '0; bus.a_in = '0; bus.b_in = '0;
      repeat (2) @(negedge clk);
      reset = 0;
      // single operation
      set_op(0, 8'd129, 8'd1);
      bus.req = 4'b0001;
      wait_grant(g); chk("t1_grant", g, 0);
      wait_pulse(p, e, c);
      chk("t1_idx", p, 0); chk("t1_kind", 32'(e), 0); chk("t1_latency", c, 6);
      chk("t1_result", 32'(bus.result), 32'h0000FF81); chk("t1_model", 32'(m_res), 32'h0000FF81);
      chk("t1_en_recover", 32'(bus.mul_en), 0);
      bus.req = '0;
      @(negedge clk); chk("t1_single_pulse", 32'(bus.done), 0);
      // contention from reset
      reset = 1;
      set_op(0, 8'd3, 8'd4); set_op(1, 8'hFE, 8'd7); set_op(2, 8'd127, 8'd127); set_op(3, 8'h80, 8'h80);
      bus.req = 4'b1111;
      repeat (2) @(negedge clk);
      reset = 0;
      for (int i = 0; i < N; i++) begin
         wait_grant(g); chk($sformatf("t2_grant%0d", i), g, i);
         wait_pulse(p, e, c); chk($sformatf("t2_done%0d", i), p, i);
         chk($sformatf("t2_result%0d", i), 32'(bus.result), 32'(t2p[i]));
         bus.req[i] = 0;
      end
      // fairness: 1 held, 2 raised mid-op
      set_op(1, 8'd10, 8'hFF); set_op(2, 8'd6, 8'd7);
      bus.req = 4'b0010;
      wait_grant(g); chk("t3_first", g, 1);
      repeat (2) @(negedge clk);
      bus.req[2] = 1;
      wait_pulse(p, e, c); chk("t3_done1", p, 1); chk("t3_res1", 32'(bus.result), 32'h0000FFF6);
      wait_grant(g); chk("t3_second", g, 2);
      wait_pulse(p, e, c); chk("t3_res2", 32'(bus.result), 32'h0000002A);
      bus.req[2] = 0;
      wait_grant(g); chk("t3_third", g, 1);
      wait_pulse(p, e, c);
      bus.req[1] = 0;
      // timeout with a hung multiplier, then next requester served
      lat = 1000;
      set_op(3, 8'd9, 8'd9); set_op(0, 8'hFF, 8'hFF);
      bus.req = 4'b1001;
      wait_grant(g); chk("t4_grant", g, 3);
      wait_pulse(p, e, c);
      chk("t4_err_idx", p, 3); chk("t4_kind", 32'(e), 1); chk("t4_err_cycles", c, T + 2);
      chk("t4_result_kept", 32'(bus.result), 32'h0000FFF6);
      bus.req[3] = 0; lat = 2;
      wait_grant(g); chk("t4_next", g, 0);
      wait_pulse(p, e, c); chk("t4_next_kind", 32'(e), 0); chk("t4_next_lat", c, 5);
      chk("t4_next_res", 32'(bus.result), 32'h00000001);
      bus.req[0] = 0;
      // ready on the last allowed cycle wins, one cycle later times out
      lat = T - 1; bus.req[2] = 1;
      wait_grant(g); wait_pulse(p, e, c);
      chk("tie_kind", 32'(e), 0); chk("tie_cycles", c, T + 2); chk("tie_res", 32'(bus.result), 32'h0000002A);
      bus.req[2] = 0;
      lat = T; bus.req[2] = 1;
      wait_grant(g); wait_pulse(p, e, c);
      chk("late_kind", 32'(e), 1); chk("late_cycles", c, T + 2);
      bus.req[2] = 0;
      // reset in WAIT
      lat = 10; set_op(1, 8'd20, 8'd3); bus.req = 4'b0010;
      wait_grant(g); chk("t5_grant", g, 1);
      repeat (3) @(negedge clk);
      reset = 1;
      @(negedge clk);
      reset = 0; bus.req = '0;
      chk("t5_en", 32'(bus.mul_en), 0); chk("t5_grant0", 32'(bus.grant), 0); chk("t5_busy", 32'(bus.busy), 0);
      n = 0;
      repeat (20) begin @(negedge clk); if (|bus.done || |bus.err) n++; end
      chk("t5_no_pulse", n, 0); chk("t5_result", 32'(bus.result), 0);
      // requester drops req mid-operation
      lat = 4; set_op(0, 8'd5, 8'hFD); bus.req = 4'b0001;
      wait_grant(g); chk("t6_grant", g, 0);
      repeat (2) @(negedge clk);
      bus.req = '0;
      n = 0;
      repeat (15) begin @(negedge clk); if (|bus.done || |bus.err) n++; end
      chk("t6_no_done", n, 0); chk("t6_result", 32'(bus.result), 32'h0000FFF1);
      chk("t6_model", 32'(m_res), 32'h0000FFF1);
      set_op(1, 8'd2, 8'd3); bus.req = 4'b0011;
      wait_grant(g); chk("t6_ptr_adv", g, 1);
      wait_pulse(p, e, c); chk("t6_res1", 32'(bus.result), 32'h00000006);
      bus.req = '0;
      repeat (3) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
